multi_ch_fault_mon: RTL and testbench



---
 rtl/fault_mon_pkg.sv | 15 +
 rtl/fault_ch_fsm.sv | 113 +++++++++++
 rtl/multi_ch_fault_mon.sv | 57 +++++
 tb/tb_multi_ch_fault_mon.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_mon_pkg.sv
// Shared definitions for the multi-channel fault monitor: channel state encoding
// and the bit positions of the per-channel cause vector {i_hi, v_lo, v_hi}.
package fault_mon_pkg;

  localparam logic [1:0] ST_NORMAL   = 2'd0;
  localparam logic [1:0] ST_WARNING  = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;
  localparam logic [1:0] ST_SHUTDOWN = 2'd3;

  localparam int CAUSE_VHI = 0;
  localparam int CAUSE_VLO = 1;
  localparam int CAUSE_IHI = 2;
  localparam int CAUSE_W   = 3;

endpackage

// File: rtl/fault_ch_fsm.sv
// One monitored channel: debounce FSM, abnormal-sample counter and optional cause log.
// Cause capture is built only when FAULT_MON_CAUSE_LOG_EN is defined.
module fault_ch_fsm
  import fault_mon_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sample_vld,
  input  logic               clr,
  input  logic [CAUSE_W-1:0] cmp,
  output logic               warning,
  output logic               fault,
  output logic               shutdown,
  output logic [CAUSE_W-1:0] cause
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_inc_s;
  logic          abnormal_s;

  assign abnormal_s  = |cmp;
  assign count_inc_s = count_r + CW'(1);

  // next-state and counter decode; count peaks at DEBOUNCE-1 so it cannot wrap
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    case (state_r)
      ST_NORMAL: begin
        if (sample_vld && abnormal_s) begin
          state_s = ST_WARNING;
          count_s = CW'(1);
        end else begin
          state_s = ST_NORMAL;
        end
      end
      ST_WARNING: begin
        if (!sample_vld) begin
          state_s = ST_WARNING;
        end else if (!abnormal_s) begin
          state_s = ST_NORMAL;
          count_s = {CW{1'b0}};
        end else if (count_inc_s == DEB_C) begin
          state_s = ST_FAULT;
          count_s = {CW{1'b0}};
        end else begin
          count_s = count_inc_s;
        end
      end
      ST_FAULT: begin
        state_s = ST_SHUTDOWN;
        count_s = {CW{1'b0}};
      end
      ST_SHUTDOWN: begin
        if (clr && sample_vld && !abnormal_s) begin
          state_s = ST_NORMAL;
        end else begin
          state_s = ST_SHUTDOWN;
        end
        count_s = {CW{1'b0}};
      end
      default: begin
        state_s = ST_NORMAL;
        count_s = {CW{1'b0}};
      end
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_NORMAL;
      count_r <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      count_r <= count_s;
    end
  end

  assign warning  = (state_r == ST_WARNING);
  assign fault    = (state_r == ST_FAULT) || (state_r == ST_SHUTDOWN);
  assign shutdown = (state_r == ST_SHUTDOWN);

`ifdef FAULT_MON_CAUSE_LOG_EN
  logic [CAUSE_W-1:0] cause_r;

  // latch the compare results of the sample that completes debounce
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cause_r <= {CAUSE_W{1'b0}};
    end else if ((state_r == ST_WARNING) && (state_s == ST_FAULT)) begin
      cause_r <= cmp;
    end else if ((state_r == ST_SHUTDOWN) && (state_s == ST_NORMAL)) begin
      cause_r <= {CAUSE_W{1'b0}};
    end else begin
      cause_r <= cause_r;
    end
  end

  assign cause = cause_r;
`else
  assign cause = {CAUSE_W{1'b0}};
`endif

endmodule

// File: rtl/multi_ch_fault_mon.sv
// Multi-channel voltage/current fault monitor: per-channel threshold compares
// feeding independent debounce FSMs. Optional cause log: FAULT_MON_CAUSE_LOG_EN.
module multi_ch_fault_mon
  import fault_mon_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int DEBOUNCE = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sample_vld,
  input  logic [NCH*DW-1:0]      volt,
  input  logic [NCH*DW-1:0]      curr,
  input  logic [DW-1:0]          v_hi,
  input  logic [DW-1:0]          v_lo,
  input  logic [DW-1:0]          i_hi,
  input  logic                   clr,
  output logic [NCH-1:0]         warning,
  output logic [NCH-1:0]         fault,
  output logic                   shutdown,
  output logic [CAUSE_W*NCH-1:0] cause
);

  logic [NCH-1:0] ch_sd_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0]      v_s;
    logic [DW-1:0]      c_s;
    logic [CAUSE_W-1:0] cmp_s;

    assign v_s = volt[i*DW +: DW];
    assign c_s = curr[i*DW +: DW];

    // thresholds are strict: a sample equal to a limit is normal
    assign cmp_s[CAUSE_VHI] = (v_s > v_hi);
    assign cmp_s[CAUSE_VLO] = (v_s < v_lo);
    assign cmp_s[CAUSE_IHI] = (c_s > i_hi);

    fault_ch_fsm #(
      .DEBOUNCE (DEBOUNCE)
    ) u_fsm (
      .clk        (clk),
      .rstn       (rstn),
      .sample_vld (sample_vld),
      .clr        (clr),
      .cmp        (cmp_s),
      .warning    (warning[i]),
      .fault      (fault[i]),
      .shutdown   (ch_sd_s[i]),
      .cause      (cause[CAUSE_W*i +: CAUSE_W])
    );
  end

  assign shutdown = |ch_sd_s;

endmodule

// File: tb/tb_multi_ch_fault_mon.sv
// Self-checking bench for multi_ch_fault_mon: directed scenarios plus random
// traffic, compared every cycle against a streak-counting behavioural model.
module tb_multi_ch_fault_mon;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int DEB = 3;

`ifdef FAULT_MON_CAUSE_LOG_EN
  localparam logic [2:0] S1_CAUSE = 3'b001;
`else
  localparam logic [2:0] S1_CAUSE = 3'b000;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              sample_vld = 1'b0;
  logic [NCH*DW-1:0] volt;
  logic [NCH*DW-1:0] curr;
  logic [DW-1:0]     v_hi = 16'd5000;
  logic [DW-1:0]     v_lo = 16'd100;
  logic [DW-1:0]     i_hi = 16'd2000;
  logic              clr = 1'b0;
  logic [NCH-1:0]    warning;
  logic [NCH-1:0]    fault;
  logic              shutdown;
  logic [3*NCH-1:0]  cause;

  logic [DW-1:0] vch [NCH];
  logic [DW-1:0] cch [NCH];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model: length of the current run of valid abnormal samples, plus fault/shutdown flags
  int       m_streak [NCH];
  bit       m_flt    [NCH];
  bit       m_sd     [NCH];
  bit [2:0] m_cause  [NCH];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      volt[i*DW +: DW] = vch[i];
      curr[i*DW +: DW] = cch[i];
    end
  end

  multi_ch_fault_mon #(.NCH(NCH), .DW(DW), .DEBOUNCE(DEB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sample_vld (sample_vld),
    .volt       (volt),
    .curr       (curr),
    .v_hi       (v_hi),
    .v_lo       (v_lo),
    .i_hi       (i_hi),
    .clr        (clr),
    .warning    (warning),
    .fault      (fault),
    .shutdown   (shutdown),
    .cause      (cause)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // behavioural model update
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        m_streak[i] = 0; m_flt[i] = 1'b0; m_sd[i] = 1'b0; m_cause[i] = 3'b000;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit [2:0] c3;
        c3 = {cch[i] > i_hi, vch[i] < v_lo, vch[i] > v_hi};
        if (m_sd[i]) begin
          if (clr && sample_vld && c3 == 3'b000) begin
            m_sd[i] = 1'b0; m_streak[i] = 0; m_cause[i] = 3'b000;
          end
        end else if (m_flt[i]) begin
          m_flt[i] = 1'b0; m_sd[i] = 1'b1;
        end else if (sample_vld) begin
          if (c3 != 3'b000) begin
            m_streak[i] = m_streak[i] + 1;
            if (m_streak[i] == DEB) begin
              m_flt[i] = 1'b1; m_streak[i] = 0; m_cause[i] = c3;
            end
          end else begin
            m_streak[i] = 0;
          end
        end
      end
    end
  end

  // per-cycle comparison of DUT outputs with the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NCH-1:0]   ew, ef;
      logic             es;
      logic [3*NCH-1:0] ec;
      es = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ew[i] = (m_streak[i] > 0) && !m_flt[i] && !m_sd[i];
        ef[i] = m_flt[i] || m_sd[i];
        es = es | m_sd[i];
`ifdef FAULT_MON_CAUSE_LOG_EN
        ec[3*i +: 3] = m_cause[i];
`else
        ec[3*i +: 3] = 3'b000;
`endif
      end
      chk("model_warning",  32'(warning),  32'(ew));
      chk("model_fault",    32'(fault),    32'(ef));
      chk("model_shutdown", 32'(shutdown), 32'(es));
      chk("model_cause",    32'(cause),    32'(ec));
    end
  end

  task automatic cyc(input logic vld, input logic c);
    sample_vld = vld;
    clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic all_normal();
    for (int i = 0; i < NCH; i++) begin
      vch[i] = 16'd3000;
      cch[i] = 16'd1000;
    end
  endtask

  initial begin
    all_normal();
    chk_en = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_warning",  32'(warning),  32'd0);
    chk("rst_fault",    32'(fault),    32'd0);
    chk("rst_shutdown", 32'(shutdown), 32'd0);
    chk("rst_cause",    32'(cause),    32'd0);
    rstn = 1'b1;

    // ch0 over-voltage debounces into fault then shutdown
    vch[0] = 16'd5001;
    cyc(1'b1, 1'b0);
    chk("s1_warn1", 32'(warning), 32'h1);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("s1_fault", 32'(fault), 32'h1);
    chk("s1_warn3", 32'(warning), 32'h0);
    chk("s1_sd_early", 32'(shutdown), 32'd0);
    chk("s1_cause", 32'(cause[2:0]), 32'(S1_CAUSE));
    vch[0] = 16'd3000;
    cyc(1'b0, 1'b0);
    chk("s1_sd", 32'(shutdown), 32'd1);
    chk("s1_other", 32'(fault[3:1]), 32'd0);
    cyc(1'b1, 1'b1);
    chk("s1_clr", 32'(fault), 32'd0);

    // ch1 over-current run broken by an at-limit sample; limits themselves are normal
    cch[1] = 16'd2001;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("s2_warn", 32'(warning), 32'h2);
    cch[1] = 16'd2000;
    cyc(1'b1, 1'b0);
    chk("s2_back", 32'(warning), 32'h0);
    vch[1] = 16'd5000;
    cyc(1'b1, 1'b0);
    vch[1] = 16'd100;
    cyc(1'b1, 1'b0);
    chk("s2_edge", 32'({warning, fault}), 32'd0);
    all_normal();

    // ch2 under-voltage with gaps in sample_vld
    vch[2] = 16'd50;
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    chk("s3_hold", 32'({warning, fault}), 32'h40);
    cyc(1'b1, 1'b0);
    chk("s3_fault", 32'(fault), 32'h4);
    vch[2] = 16'd3000;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);

    // ch3 shutdown clear qualification
    vch[3] = 16'd6000;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    chk("s4_sd", 32'(shutdown), 32'd1);
    cyc(1'b1, 1'b1);
    chk("s4_clr_abn", 32'(shutdown), 32'd1);
    vch[3] = 16'd3000;
    cyc(1'b0, 1'b1);
    chk("s4_clr_idle", 32'(shutdown), 32'd1);
    cyc(1'b1, 1'b1);
    chk("s4_clr_ok", 32'({shutdown, fault, cause}), 32'd0);

    // async reset with ch0 mid-warning and ch3 in shutdown
    vch[3] = 16'd6000;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    vch[0] = 16'd5001;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    chk("s5_pre", 32'({shutdown, warning[0]}), 32'h3);
    rstn = 1'b0;
    #1;
    chk("s5_async", 32'({warning, fault, shutdown, cause}), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    vch[3] = 16'd3000;
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    chk("s5_nofault", 32'({fault, warning}), 32'h1);
    all_normal();
    cyc(1'b1, 1'b0);

    // randomized traffic including threshold changes
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 8))
          0: vch[i] = 16'd50;
          1: vch[i] = 16'd99;
          2: vch[i] = 16'd5001;
          3: vch[i] = 16'd100;
          4: vch[i] = 16'd5000;
          5: vch[i] = 16'd4500;
          default: vch[i] = 16'd3000;
        endcase
        cch[i] = ($urandom_range(0, 5) == 0) ? 16'd2001 : 16'(($urandom_range(0, 1) == 0) ? 2000 : 500);
      end
      if ($urandom_range(0, 63) == 0) v_hi = ($urandom_range(0, 1) == 0) ? 16'd4000 : 16'd5000;
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
